cory_sprom_arb: RTL and testbench
=================================

Name: cory_sprom_arb

Overview:
- Round-robin arbiter and sequencer that shares one single-port ROM (1-cycle registered read, `csn` active-low) among N requesters.
- Each requester has a valid/ready request channel (address) and a valid/ready response channel (data + error).
- Sits between client engines and the ROM model or physical macro.
- Sustains one read per cycle, with no data loss under response backpressure.

Parameters:
- N, 4, number of requesters (2..16).
- A, 8, ROM address width.
- D, 8, ROM data width.
- SIZE, 2**A, number of valid ROM words; addresses >= SIZE are rejected.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous reset, active-high.
- i_v  input  N  request valid, one bit per requester.
- i_a  input  N*A  request addresses; requester k uses bits [k*A +: A].
- i_r  output  N  request ready (grant), one-hot or zero.
- o_v  output  N  response valid, one-hot or zero.
- o_d  output  D  response data, shared by all requesters.
- o_e  output  1  response error: address was out of range.
- o_r  input  N  response ready, one bit per requester.
- mem_csn  output  1  ROM chip select, active-low.
- mem_addr  output  A  ROM address.
- mem_rdata  input  D  ROM read data, valid the cycle after `mem_csn`=0.

Behaviour:
- Reset:
  - ptr=0, resp_v=0, resp_err=0, resp_own=0.
  - Outputs: o_v=0, i_r=0, mem_csn=1, mem_addr=0.
  - Reset mid-operation drops any pending response; no replay.
- Issue condition:
  - can_issue = !resp_v || (o_r[resp_own] && o_v[resp_own]).
  - This is a combinational path from o_r to i_r and mem_csn, and it is permitted.
- Grant:
  - When can_issue, grant the first k with i_v[k]=1, searching ptr, ptr+1, ..., wrapping at N-1 -> 0.
  - i_r[k]=1 for that single k only; requester k's transfer completes this cycle.
  - No grant when !can_issue or no i_v is set; i_r=0 in that case.
- Pointer: after a grant to k, ptr <= (k+1) mod N. Otherwise ptr holds.
- ROM issue, on a granted in-range address (i_a_k < SIZE):
  - mem_csn=0 and mem_addr=i_a_k in the same cycle.
  - Next cycle: resp_v=1, resp_own=k, resp_err=0, o_d=mem_rdata.
- Out-of-range address (i_a_k >= SIZE):
  - The request is still accepted, but mem_csn stays 1.
  - Next cycle: resp_v=1, resp_err=1, o_d=0, o_e=1.
- Idle: when not issuing, mem_csn=1 and mem_addr=0.
- Latency: grant at cycle t gives o_v at t+1. The back-to-back rate is 1 per cycle while the response is accepted in the same cycle.
- Response hold:
  - o_v[resp_own]=resp_v; all other o_v bits are 0.
  - o_d comes directly from mem_rdata, which stays stable because no new read is issued while a response is pending and unaccepted.
  - o_d and o_e are 0 when resp_v=0.
- Response register update:
  - Accept with a new grant in the same cycle: register reloads with the new owner.
  - Accept without a new grant: resp_v <= 0.
- Boundaries:
  - ptr wraps at N-1.
  - A single requester may be granted every cycle.
  - A requester whose i_v drops before its grant is simply skipped.
  - i_a with X values is never driven to the ROM unless granted.

Decomposition:
- Shared header/package `cory_sprom_arb_pkg`:
  - log2 helper for the owner width (W = clog2(N)).
  - round-robin search function (ptr, request vector -> index, found).
- Natural sub-module `cory_rr_arb`:
  - N-way round-robin arbiter with pointer state.
  - Inputs: clk, reset, req[N], en. Outputs: gnt[N], gnt_idx.
  - The rest (response register, ROM interface, range check) lives in `cory_sprom_arb`.

Test Plan:
- Reset then single read:
  - ROM preloaded mem[i]=i^8'hA5.
  - Requester 2 sends addr 8'h10, o_r=all 1.
  - Required: i_r[2]=1 at t, mem_csn=0 and mem_addr=8'h10 at t, o_v[2]=1 and o_d=8'hB5 at t+1.
- Round-robin fairness:
  - All 4 requesters hold i_v=1 with o_r=all 1.
  - Required: grants 0,1,2,3,0,1 on consecutive cycles; 1 response per cycle.
- Backpressure:
  - Requester 1 reads addr 3 with o_r[1]=0 for 5 cycles.
  - Required: o_v[1]=1 and o_d=8'hA6 held stable; mem_csn=1 and i_r=0 throughout; grant to the next requester in the cycle o_r[1] rises.
- Out-of-range read:
  - SIZE=200; requester 0 sends addr 250.
  - Required: mem_csn stays 1; next cycle o_v[0]=1, o_e=1, o_d=0.
- Reset mid-stream:
  - Assert reset while a response to requester 3 is pending.
  - Required: next cycle o_v=0, mem_csn=1; first grant after reset goes to requester 0 when all request.
- Pointer wrap:
  - Only requesters 3 and 0 active.
  - Required: grants alternate 3,0,3,0.

Source files
------------

// File: rtl/cory_sprom_arb_pkg.sv
// Shared types and helpers for the single-port ROM arbiter: owner width and
// the round-robin search used by the arbiter core.
package cory_sprom_arb_pkg;

  localparam int MAX_N = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req at or after ptr, wrapping at n-1 back to 0.
  function automatic rr_pick_t rr_search(input logic [3:0] ptr,
                                         input logic [MAX_N-1:0] req,
                                         input int n);
    rr_pick_t   pick;
    logic [4:0] j;
    pick = '0;
    for (int i = 0; i < MAX_N; i++) begin
      j = {1'b0, ptr} + 5'(i);
      if (j >= 5'(n)) j = j - 5'(n);
      if (i < n && !pick.found && req[j[3:0]]) begin
        pick.found = 1'b1;
        pick.idx   = j[3:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cory_rr_arb.sv
// N-way round-robin arbiter; the pointer moves just past the last winner.
module cory_rr_arb
  import cory_sprom_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = owner_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] ptr;
  rr_pick_t     pick;

  always_comb begin
    pick    = rr_search(4'(ptr), MAX_N'(req), N);
    gnt     = '0;
    gnt_idx = pick.idx[W-1:0];
    if (en && pick.found) gnt[pick.idx[W-1:0]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && pick.found) begin
      ptr <= (pick.idx == 4'(N-1)) ? '0 : pick.idx[W-1:0] + 1'b1;
    end
  end

endmodule

// File: rtl/cory_sprom_arb.sv
// Shares one single-port ROM (1-cycle registered read) among N valid/ready
// requesters, one read per cycle, holding each response until accepted.
module cory_sprom_arb
  import cory_sprom_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int A    = 8,
  parameter int D    = 8,
  parameter int SIZE = 2**A
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   i_v,
  input  logic [N*A-1:0] i_a,
  output logic [N-1:0]   i_r,
  output logic [N-1:0]   o_v,
  output logic [D-1:0]   o_d,
  output logic           o_e,
  input  logic [N-1:0]   o_r,
  output logic           mem_csn,
  output logic [A-1:0]   mem_addr,
  input  logic [D-1:0]   mem_rdata
);

  localparam int       W     = owner_w(N);
  localparam logic [A:0] LIMIT = (A+1)'(SIZE);

  logic         resp_vld_p1;
  logic [W-1:0] resp_own_p1;
  logic         resp_err_p1;
  logic         can_issue;
  logic         granted;
  logic         in_range;
  logic         issue;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic [A-1:0] sel_addr;

  // A new read may start once the held response is gone or leaves this cycle.
  assign can_issue = !resp_vld_p1 || o_r[resp_own_p1];

  cory_rr_arb #(.N(N), .W(W)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (i_v),
    .en      (can_issue && !reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // AND-OR select so ungranted (possibly undriven) addresses never reach the ROM.
  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) sel_addr = i_a[k*A +: A];
    end
  end

  assign granted  = |gnt;
  assign in_range = {1'b0, sel_addr} < LIMIT;
  assign issue    = granted && in_range;
  assign mem_csn  = !issue;
  assign mem_addr = issue ? sel_addr : '0;
  assign i_r      = gnt;

  // Stage p1: response register; data is taken straight from the ROM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_vld_p1 <= 1'b0;
      resp_own_p1 <= '0;
      resp_err_p1 <= 1'b0;
    end else if (granted) begin
      resp_vld_p1 <= 1'b1;
      resp_own_p1 <= gnt_idx;
      resp_err_p1 <= !in_range;
    end else if (can_issue) begin
      resp_vld_p1 <= 1'b0;
    end
  end

  assign o_v = resp_vld_p1 ? (N'(1) << resp_own_p1) : '0;
  assign o_d = (resp_vld_p1 && !resp_err_p1) ? mem_rdata : '0;
  assign o_e = resp_vld_p1 && resp_err_p1;

endmodule

// File: tb/tb_cory_sprom_arb.sv
// Bench for cory_sprom_arb: vector table, multi-cycle sequences and a random
// run against a behavioural model of the arbiter and ROM contents.
module tb_cory_sprom_arb;

  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;
  localparam int SIZE = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  i_v = '0;
  logic [N*A-1:0] i_a = '0;
  logic [N-1:0]  i_r;
  logic [N-1:0]  o_v;
  logic [D-1:0]  o_d;
  logic          o_e;
  logic [N-1:0]  o_r = '0;
  logic          mem_csn;
  logic [A-1:0]  mem_addr;
  logic [D-1:0]  mem_rdata = '0;

  logic [D-1:0]  rom [256];
  int            errors = 0;
  int            checks = 0;

  cory_sprom_arb #(.N(N), .A(A), .D(D), .SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_v       (i_v),
    .i_a       (i_a),
    .i_r       (i_r),
    .o_v       (o_v),
    .o_d       (o_d),
    .o_e       (o_e),
    .o_r       (o_r),
    .mem_csn   (mem_csn),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;

  always @(posedge clk) if (!mem_csn) mem_rdata <= rom[mem_addr];

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] ia;
    logic [3:0]  orr;
    logic [3:0]  ir;
    logic        csn;
    logic [7:0]  maddr;
    logic [3:0]  ov;
    logic [7:0]  od;
    logic        oe;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] a,
                       input logic [3:0] rr);
    @(posedge clk);
    #1;
    reset = r;
    i_v   = v;
    i_a   = a;
    o_r   = rr;
    #3;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_ir, input logic e_csn,
                         input logic [7:0] e_maddr, input logic [3:0] e_ov,
                         input logic [7:0] e_od, input logic e_oe);
    chk({tag, ".i_r"}, 32'(i_r), 32'(e_ir));
    chk({tag, ".mem_csn"}, 32'(mem_csn), 32'(e_csn));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e_maddr));
    chk({tag, ".o_v"}, 32'(o_v), 32'(e_ov));
    chk({tag, ".o_d"}, 32'(o_d), 32'(e_od));
    chk({tag, ".o_e"}, 32'(o_e), 32'(e_oe));
  endtask

  // Reference model state: pointer plus the one outstanding response.
  int          m_ptr;
  logic        m_pv;
  int          m_own;
  logic        m_err;
  logic [7:0]  m_addr;

  task automatic model_cycle(input int cyc, input logic r, input logic [3:0] v,
                             input logic [31:0] a, input logic [3:0] rr);
    logic [3:0] e_ov, e_ir;
    logic [7:0] e_od, e_maddr, ad;
    logic       e_oe, e_csn, can, found;
    int         k;
    e_ov  = m_pv ? 4'(1 << m_own) : 4'h0;
    e_od  = (m_pv && !m_err) ? (m_addr ^ 8'hA5) : 8'h00;
    e_oe  = m_pv && m_err;
    can   = !m_pv || rr[m_own];
    found = 1'b0;
    k     = 0;
    if (!r && can) begin
      for (int i = 0; i < N; i++) begin
        if (!found && v[(m_ptr + i) % N]) begin
          found = 1'b1;
          k     = (m_ptr + i) % N;
        end
      end
    end
    ad      = a[k*8 +: 8];
    e_ir    = found ? 4'(1 << k) : 4'h0;
    e_csn   = !(found && ad < SIZE);
    e_maddr = (found && ad < SIZE) ? ad : 8'h00;
    chk_all($sformatf("rand%0d", cyc), e_ir, e_csn, e_maddr, e_ov, e_od, e_oe);
    if (r) begin
      m_ptr = 0; m_pv = 1'b0; m_own = 0; m_err = 1'b0;
    end else if (found) begin
      m_pv = 1'b1; m_own = k; m_err = (ad >= SIZE); m_addr = ad;
      m_ptr = (k + 1) % N;
    end else if (can) begin
      m_pv = 1'b0;
    end
  endtask

  initial begin
    logic        r;
    logic [3:0]  v, rr;
    logic [31:0] a;

    tbl[0]  = '{1'b1, 4'hF, 32'h00000000, 4'hF, 4'h0, 1'b1, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 4'h4, 32'h00100000, 4'hF, 4'h4, 1'b0, 8'h10, 4'h0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 32'h00000000, 4'hF, 4'h0, 1'b1, 8'h00, 4'h4, 8'hB5, 1'b0};
    tbl[3]  = '{1'b1, 4'h0, 32'h00000000, 4'hF, 4'h0, 1'b1, 8'h00, 4'h0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 32'h04030201, 4'hF, 4'h1, 1'b0, 8'h01, 4'h0, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 32'h04030201, 4'hF, 4'h2, 1'b0, 8'h02, 4'h1, 8'hA4, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 32'h04030201, 4'hF, 4'h4, 1'b0, 8'h03, 4'h2, 8'hA7, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 32'h04030201, 4'hF, 4'h8, 1'b0, 8'h04, 4'h4, 8'hA6, 1'b0};
    tbl[8]  = '{1'b0, 4'hF, 32'h04030201, 4'hF, 4'h1, 1'b0, 8'h01, 4'h8, 8'hA1, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 32'h04030201, 4'hF, 4'h2, 1'b0, 8'h02, 4'h1, 8'hA4, 1'b0};
    tbl[10] = '{1'b0, 4'h1, 32'h000000FA, 4'hF, 4'h1, 1'b1, 8'h00, 4'h2, 8'hA7, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 32'h00000000, 4'hF, 4'h0, 1'b1, 8'h00, 4'h1, 8'h00, 1'b1};
    tbl[12] = '{1'b0, 4'h9, 32'h06000005, 4'hF, 4'h8, 1'b0, 8'h06, 4'h0, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 4'h9, 32'h06000005, 4'hF, 4'h1, 1'b0, 8'h05, 4'h8, 8'hA3, 1'b0};
    tbl[14] = '{1'b0, 4'h9, 32'h06000005, 4'hF, 4'h8, 1'b0, 8'h06, 4'h1, 8'hA0, 1'b0};
    tbl[15] = '{1'b0, 4'h9, 32'h06000005, 4'hF, 4'h1, 1'b0, 8'h05, 4'h8, 8'hA3, 1'b0};
    tbl[16] = '{1'b0, 4'h0, 32'h00000000, 4'hF, 4'h0, 1'b1, 8'h00, 4'h1, 8'hA0, 1'b0};
    tbl[17] = '{1'b0, 4'h4, 32'h00070000, 4'hF, 4'h4, 1'b0, 8'h07, 4'h0, 8'h00, 1'b0};
    tbl[18] = '{1'b0, 4'h4, 32'h00080000, 4'hF, 4'h4, 1'b0, 8'h08, 4'h4, 8'hA2, 1'b0};
    tbl[19] = '{1'b0, 4'h0, 32'h00000000, 4'hF, 4'h0, 1'b1, 8'h00, 4'h4, 8'hAD, 1'b0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].ia, tbl[i].orr);
      chk_all($sformatf("vec%0d", i), tbl[i].ir, tbl[i].csn, tbl[i].maddr,
              tbl[i].ov, tbl[i].od, tbl[i].oe);
    end

    // Backpressure: requester 1 reads addr 3, then holds o_r[1] low for 5 cycles.
    drive(1'b0, 4'h2, 32'h00000300, 4'hF);
    chk("bp.grant", 32'(i_r), 32'h2);
    chk("bp.csn", 32'(mem_csn), 32'h0);
    chk("bp.addr", 32'(mem_addr), 32'h03);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'h5, 32'h00090011, 4'b1101);
      chk_all($sformatf("bp.hold%0d", c), 4'h0, 1'b1, 8'h00, 4'h2, 8'hA6, 1'b0);
    end
    drive(1'b0, 4'h5, 32'h00090011, 4'hF);
    chk_all("bp.release", 4'h4, 1'b0, 8'h09, 4'h2, 8'hA6, 1'b0);
    drive(1'b0, 4'h0, 32'h00000000, 4'hF);
    chk_all("bp.next", 4'h0, 1'b1, 8'h00, 4'h4, 8'hAC, 1'b0);

    // Reset while a response to requester 3 is pending.
    drive(1'b0, 4'h8, 32'h20000000, 4'h0);
    chk("rst.grant3", 32'(i_r), 32'h8);
    drive(1'b1, 4'hF, 32'h20000011, 4'h0);
    chk_all("rst.during", 4'h0, 1'b1, 8'h00, 4'h8, 8'h85, 1'b0);
    drive(1'b0, 4'hF, 32'h20000011, 4'hF);
    chk_all("rst.after", 4'h1, 1'b0, 8'h11, 4'h0, 8'h00, 1'b0);

    m_ptr = 1; m_pv = 1'b1; m_own = 0; m_err = 1'b0; m_addr = 8'h11;
    for (int c = 0; c < 2000; c++) begin
      r  = (c == 0) || ($urandom_range(0, 63) == 0);
      v  = 4'($urandom_range(0, 15));
      a  = $urandom;
      rr = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      drive(r, v, a, rr);
      model_cycle(c, r, v, a, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
